// File: rtl/bsa_sub_seq.sv
// Multi-cycle borrow-skip subtractor: one M*K-bit slice per edge, result valid C edges after accept.
// Valid/ready on both sides; in_ready only in IDLE, result held in DONE until out_ready.
module bsa_sub_seq #(
  parameter int N = 512,
  parameter int M = 4,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         Ovf,
  output logic         busy
);

  localparam int W  = M * K;
  localparam int C  = N / W;
  localparam int IW = (C > 1) ? $clog2(C) : 1;
  localparam logic [IW-1:0] LAST = IW'(C - 1);

  generate
    if (N % W != 0) begin : g_bad_width
      $error("bsa_sub_seq: N must be a multiple of M*K");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          borrow_q, borrow_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  logic [W-1:0]  a_sl, b_sl, d_sl;
  logic          chain_b, grp_b, grp_eq, ai, bi;
  int            base;

  // Slice datapath: each group ripples internally, but its borrow-out skips
  // straight from its borrow-in when every bit pair is equal.
  always_comb begin
    base    = int'(idx_q) * W;
    a_sl    = a_q[base +: W];
    b_sl    = b_q[base +: W];
    d_sl    = '0;
    chain_b = borrow_q;
    grp_b   = 1'b0;
    grp_eq  = 1'b0;
    ai      = 1'b0;
    bi      = 1'b0;
    for (int g = 0; g < K; g++) begin
      grp_b  = chain_b;
      grp_eq = 1'b1;
      for (int i = 0; i < M; i++) begin
        ai             = a_sl[g*M+i];
        bi             = b_sl[g*M+i];
        d_sl[g*M+i]    = ai ^ bi ^ grp_b;
        grp_b          = (~ai & bi) | (~(ai ^ bi) & grp_b);
        grp_eq         = grp_eq & ~(ai ^ bi);
      end
      chain_b = grp_eq ? chain_b : grp_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    borrow_d    = borrow_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = B;
          idx_d      = '0;
          borrow_d   = 1'b0;
          state_d    = S_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        diff_d[base +: W] = d_sl;
        borrow_d          = chain_b;
        idx_d             = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d       = '0;
          bout_d      = chain_b;
          // The last slice carries the MSB of the difference.
          ovf_d       = (a_q[N-1] ^ b_q[N-1]) & (d_sl[W-1] ^ a_q[N-1]);
          state_d     = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      borrow_q    <= borrow_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;
  assign Ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bsa_sub_seq.sv
// Directed bench for bsa_sub_seq: small N=16 (C=2) and N=8 (C=1) instances plus a default-size random run.
module tb_bsa_sub_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // N=16, M=4, K=2 -> C=2
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_bout, s_ovf, s_busy;
  logic [15:0] s_a, s_b, s_diff;
  bsa_sub_seq #(.N(16), .M(4), .K(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .A(s_a), .B(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .Diff(s_diff), .Bout(s_bout),
    .Ovf(s_ovf), .busy(s_busy));

  // N=8, M=4, K=2 -> C=1
  logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_bout, o_ovf, o_busy;
  logic [7:0]  o_a, o_b, o_diff;
  bsa_sub_seq #(.N(8), .M(4), .K(2)) u_one (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready), .A(o_a), .B(o_b),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .Diff(o_diff), .Bout(o_bout),
    .Ovf(o_ovf), .busy(o_busy));

  // Defaults: N=512, M=4, K=8 -> C=16
  logic         g_in_valid, g_in_ready, g_out_valid, g_out_ready, g_bout, g_ovf, g_busy;
  logic [511:0] g_a, g_b, g_diff;
  bsa_sub_seq u_big (
    .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready), .A(g_a), .B(g_b),
    .out_valid(g_out_valid), .out_ready(g_out_ready), .Diff(g_diff), .Bout(g_bout),
    .Ovf(g_ovf), .busy(g_busy));

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge with the small DUT idle; returns at a negedge, idle again.
  task automatic small_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic ebo, input logic eov);
    int lat;
    s_a = a; s_b = b; s_in_valid = 1'b1;
    check({tag, "_in_ready"}, s_in_ready, 1);
    @(posedge clk); @(negedge clk);
    s_in_valid = 1'b0;
    check({tag, "_busy"}, s_busy, 1);
    lat = 0;
    while (!s_out_valid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_diff"}, s_diff, ed);
    check({tag, "_bout"}, s_bout, ebo);
    check({tag, "_ovf"}, s_ovf, eov);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check({tag, "_drop"}, s_out_valid, 0);
    check({tag, "_idle"}, s_in_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0]   ova [2], ovb [2], ovd [2];
    logic         ovbo [2], ovov [2];
    logic [511:0] ra, rb;
    logic [512:0] rr;
    logic         rov, hs;

    rst = 1'b1;
    s_in_valid = 0; s_out_ready = 0; s_a = '0; s_b = '0;
    o_in_valid = 0; o_out_ready = 0; o_a = '0; o_b = '0;
    g_in_valid = 0; g_out_ready = 0; g_a = '0; g_b = '0;
    #1;
    check("rst_in_ready", s_in_ready, 1);
    check("rst_out_valid", s_out_valid, 0);
    check("rst_busy", s_busy, 0);
    check("rst_diff", s_diff, 0);
    check("rst_bout", s_bout, 0);
    check("rst_ovf", s_ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    small_op("t1", 16'h1234, 16'h0234, 16'h1000, 0, 0);
    small_op("t2", 16'h0000, 16'h0001, 16'hFFFF, 1, 0);
    small_op("t3a", 16'h8000, 16'h0001, 16'h7FFF, 0, 1);
    small_op("t3b", 16'h7FFF, 16'hFFFF, 16'h8000, 1, 1);
    small_op("t3c", 16'h4321, 16'h4321, 16'h0000, 0, 0);

    // Hold in DONE with new operands pending; they must not be taken.
    s_a = 16'h00FF; s_b = 16'h000F; s_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    s_a = 16'hAAAA; s_b = 16'h1111;
    lat = 0;
    while (!s_out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("t4_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", s_out_valid, 1);
      check("t4_hold_in_ready", s_in_ready, 0);
      check("t4_hold_diff", s_diff, 16'h00F0);
      check("t4_hold_bout", s_bout, 0);
      @(negedge clk);
    end
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("t4_release_valid", s_out_valid, 0);
    check("t4_release_in_ready", s_in_ready, 1);
    @(negedge clk);
    s_in_valid = 1'b0;
    check("t4_accept_busy", s_busy, 1);
    lat = 0;
    while (!s_out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("t4_new_latency", lat, 2);
    check("t4_new_diff", s_diff, 16'h9999);
    check("t4_new_bout", s_bout, 0);
    check("t4_new_ovf", s_ovf, 0);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;

    // Reset after the first RUN edge discards the operation.
    s_a = 16'h1234; s_b = 16'h0001; s_in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    check("t5_pre_busy", s_busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", s_out_valid, 0);
    check("t5_rst_diff", s_diff, 0);
    check("t5_rst_bout", s_bout, 0);
    check("t5_rst_ovf", s_ovf, 0);
    check("t5_rst_busy", s_busy, 0);
    check("t5_rst_in_ready", s_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    small_op("t5_after", 16'h5555, 16'h6666, 16'hEEEF, 1, 0);

    // C=1: RUN lasts a single edge.
    ova[0] = 8'h05; ovb[0] = 8'h07; ovd[0] = 8'hFE; ovbo[0] = 1; ovov[0] = 0;
    ova[1] = 8'h80; ovb[1] = 8'h01; ovd[1] = 8'h7F; ovbo[1] = 0; ovov[1] = 1;
    for (int v = 0; v < 2; v++) begin
      o_a = ova[v]; o_b = ovb[v]; o_in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      o_in_valid = 1'b0;
      lat = 0;
      while (!o_out_valid && lat < 20) begin @(negedge clk); lat++; end
      check("c1_latency", lat, 1);
      check("c1_diff", o_diff, ovd[v]);
      check("c1_bout", o_bout, ovbo[v]);
      check("c1_ovf", o_ovf, ovov[v]);
      o_out_ready = 1'b1;
      @(negedge clk);
      o_out_ready = 1'b0;
    end

    // Default size, back-to-back random ops against an arithmetic reference.
    for (int op = 0; op < 2000; op++) begin
      ra = rand512();
      case ($urandom_range(0, 3))
        0: rb = rand512();
        1: begin rb = ra; rb[$urandom_range(0, 511)] ^= 1'b1; end
        2: rb = ra;
        default: rb = ra + 512'(($urandom_range(0, 1) != 0) ? 1 : -1);
      endcase
      rr  = {1'b0, ra} - {1'b0, rb};
      rov = (ra[511] != rb[511]) && (rr[511] != ra[511]);
      g_a = ra; g_b = rb; g_in_valid = 1'b1;
      check("big_in_ready", g_in_ready, 1);
      @(posedge clk); @(negedge clk);
      g_in_valid = 1'b0;
      lat = 0;
      while (!g_out_valid && lat < 40) begin @(negedge clk); lat++; end
      check("big_latency", lat, 16);
      check("big_diff", g_diff, rr[511:0]);
      check("big_bout", g_bout, rr[512]);
      check("big_ovf", g_ovf, rov);
      hs = 1'b0;
      for (int w = 0; w < 50 && !hs; w++) begin
        g_out_ready = ($urandom_range(0, 1) != 0);
        hs = g_out_ready;
        @(negedge clk);
        if (!hs) check("big_hold_diff", g_diff, rr[511:0]);
      end
      g_out_ready = 1'b0;
      check("big_drop", g_out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
